// File: rtl/hazard_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_scheduler
//  Purpose  : Pipeline hazard controller for the 5-stage core. It sits beside
//             the ID stage, keeps a private shadow copy of the destination
//             registers of the instructions in flight (slot 1 = EXE,
//             slot 2 = MEM, slot 3 = an optional extra stage), and stalls ID
//             on read-after-write dependencies. A frozen instruction or a
//             taken-branch flush inserts a bubble into the shadow pipeline.
//             A saturating counter records the number of stalled cycles.
//
//  Optional : FORWARDING_EN - when defined, only load-use dependencies on the
//             EXE slot stall. Every other dependency is resolved by the
//             forward selects (1 = EXE result, 2 = MEM result, 0 = regfile).
//             When undefined, every dependency stalls and the forward selects
//             are tied to 0.
//
//  Parameters
//    DEPTH        number of shadow slots checked for RAW hazards (1..3)
//    COUNT_W      width of the stall counter
//
//  Ports
//    clock        in   1        system clock, rising edge
//    reset        in   1        asynchronous active-low reset
//    id_valid     in   1        ID holds a real instruction (0 = bubble)
//    src1         in   5        rs field of the ID instruction
//    src2         in   5        rt field of the ID instruction
//    src2_used    in   1        ID instruction reads rt
//    wb_en_id     in   1        ID instruction writes back
//    dest_id      in   5        ID instruction destination register
//    mem_read_id  in   1        ID instruction is a load
//    branch_taken in   1        branch resolved taken in EXE this cycle
//    freez        out  1        stall IF/ID and zero ID control outputs
//    flush        out  1        squash IF/ID contents this cycle
//    fwd_sel1     out  2        operand-1 forward select
//    fwd_sel2     out  2        operand-2 forward select
//    stall_count  out  COUNT_W  cycles with freez=1 since reset (saturating)
//
//  Revision : 1.0 - initial release
// ============================================================================
module hazard_scheduler #(
  parameter int DEPTH   = 2,
  parameter int COUNT_W = 32
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               id_valid,
  input  logic [4:0]         src1,
  input  logic [4:0]         src2,
  input  logic               src2_used,
  input  logic               wb_en_id,
  input  logic [4:0]         dest_id,
  input  logic               mem_read_id,
  input  logic               branch_taken,
  output logic               freez,
  output logic               flush,
  output logic [1:0]         fwd_sel1,
  output logic [1:0]         fwd_sel2,
  output logic [COUNT_W-1:0] stall_count
);

  // --------------------------------------------------------------------------
  // Shadow pipeline: one entry per in-flight stage, index 1 is the youngest.
  // --------------------------------------------------------------------------
  logic [DEPTH:1]     r_wb;
  logic [DEPTH:1]     r_mr;
  logic [4:0]         r_dest [1:DEPTH];
  logic [COUNT_W-1:0] r_cnt;

  // Per-slot dependency flags for each source operand. Register 0 is
  // hard-wired to zero and can never carry a dependency.
  logic [DEPTH:1]     w_m1;
  logic [DEPTH:1]     w_m2;
  logic               w_hazard;
  logic               w_squash;

  for (genvar k = 1; k <= DEPTH; k++) begin : g_match
    assign w_m1[k] = r_wb[k] && (r_dest[k] == src1) && (src1 != 5'd0);
    // src2_used is folded in here so neither the stall nor the forward
    // select ever reacts to an rt field that the instruction ignores.
    assign w_m2[k] = src2_used && r_wb[k] && (r_dest[k] == src2) && (src2 != 5'd0);
  end

`ifdef FORWARDING_EN
  // Only a load in EXE cannot be forwarded in time; everything else is
  // bypassed, so the stall condition narrows to load-use on slot 1.
  assign w_hazard = r_mr[1] && (w_m1[1] || w_m2[1]);

  logic w_mem_m1;
  logic w_mem_m2;

  if (DEPTH >= 2) begin : g_fwd_mem
    assign w_mem_m1 = w_m1[2];
    assign w_mem_m2 = w_m2[2];
  end else begin : g_fwd_nomem
    assign w_mem_m1 = 1'b0;
    assign w_mem_m2 = 1'b0;
  end

  // The EXE result is the most recent value, so slot 1 takes priority.
  always_comb begin
    fwd_sel1 = 2'd0;
    fwd_sel2 = 2'd0;
    if (w_m1[1]) begin
      fwd_sel1 = 2'd1;
    end else if (w_mem_m1) begin
      fwd_sel1 = 2'd2;
    end
    if (w_m2[1]) begin
      fwd_sel2 = 2'd1;
    end else if (w_mem_m2) begin
      fwd_sel2 = 2'd2;
    end
  end
`else
  // Without bypassing, any pending write to a source register must drain
  // through every tracked slot before ID may proceed.
  assign w_hazard = (|w_m1) || (|w_m2);
  assign fwd_sel1 = 2'd0;
  assign fwd_sel2 = 2'd0;
`endif

  // The last slot's load flag and, with forwarding, the deeper match flags
  // have no consumer; collected here so their absence of readers is explicit.
  logic w_unused_bits;
  assign w_unused_bits = ^{r_mr, w_m1, w_m2};

  // A taken branch overrides any hazard: the ID instruction is being
  // squashed anyway, so stalling it would only waste a cycle.
  assign freez = id_valid && !branch_taken && w_hazard;
  assign flush = branch_taken;

  // Bubble into EXE when ID is stalled, squashed, or empty.
  assign w_squash = freez || branch_taken || !id_valid;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wb <= '0;
      r_mr <= '0;
      for (int k = 1; k <= DEPTH; k++) begin
        r_dest[k] <= 5'd0;
      end
    end else begin
      if (w_squash) begin
        r_wb[1]   <= 1'b0;
        r_mr[1]   <= 1'b0;
        r_dest[1] <= 5'd0;
      end else begin
        r_wb[1]   <= wb_en_id;
        r_mr[1]   <= mem_read_id;
        r_dest[1] <= dest_id;
      end
      // Older slots advance unconditionally, so a stalled instruction
      // watches its producer move down and out of the tracked window.
      for (int k = 2; k <= DEPTH; k++) begin
        r_wb[k]   <= r_wb[k-1];
        r_mr[k]   <= r_mr[k-1];
        r_dest[k] <= r_dest[k-1];
      end
    end
  end

  // Saturating stall counter: holds at all-ones rather than wrapping.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (freez && !(&r_cnt)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign stall_count = r_cnt;

endmodule
`default_nettype wire
